systolic_skew_feeder: RTL and testbench



---
 rtl/systolic_skew_feeder.sv | 113 +++++++++++
 tb/tb_systolic_skew_feeder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: holds an NxN A and NxN B operand matrix and, on start,
// streams them diagonally skewed into the west (A) and north (B) edges of an
// output-stationary systolic array, then pulses done once every PE is final.
module systolic_skew_feeder #(
   parameter int DATAWIDTH = 8,
   parameter int N         = 3
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   wr_en,
   input  logic                   wr_sel,
   input  logic [$clog2(N*N)-1:0] wr_addr,
   input  logic [DATAWIDTH-1:0]   wr_data,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [N*DATAWIDTH-1:0] A_out,
   output logic [N*DATAWIDTH-1:0] B_out
);

   localparam int AW = $clog2(N*N);
   localparam int CW = $clog2(3*N);
   // last step index that still carries operands
   localparam logic [CW-1:0] LAST_STEP = CW'(2*N-2);
   // edge (counted from the start edge) at which PE(N-1,N-1) has its last product
   localparam logic [CW-1:0] LAST_CNT  = CW'(3*N-2);

   typedef enum logic [1:0] {IDLE, FEED, FLUSH} state_t;

   state_t                            state;
   logic [CW-1:0]                     cnt;
   logic [CW-1:0]                     cnt_inc;
   logic [CW-1:0]                     step;
   logic [N*N-1:0][DATAWIDTH-1:0]     a_mem;
   logic [N*N-1:0][DATAWIDTH-1:0]     b_mem;
   logic [N-1:0][DATAWIDTH-1:0]       a_step;
   logic [N-1:0][DATAWIDTH-1:0]       b_step;
   logic                              wr_ok;

   assign cnt_inc = cnt + CW'(1);
   // step index whose lane values get registered at the coming edge
   assign step    = (state == IDLE) ? '0 : cnt_inc;
   // the store is frozen while a sequence runs, and out-of-range words are dropped
   assign wr_ok   = wr_en && (state == IDLE) &&
                    ({1'b0, wr_addr} < (AW+1)'(N*N));

   // matrix store; reset wipes it so a post-reset start streams zeros
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a_mem <= '0;
         b_mem <= '0;
      end else if (wr_ok) begin
         if (wr_sel) b_mem[wr_addr] <= wr_data;
         else        a_mem[wr_addr] <= wr_data;
      end
   end

   // skew selection: lane i shows A[i][s-i], lane j shows B[s-j][j]; anything
   // off the diagonal band (including every step past 2N-2) falls out as zero
   always_comb begin
      a_step = '0;
      b_step = '0;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < N; k++) begin
            if (step == CW'(i + k)) begin
               a_step[i] = a_mem[AW'(i*N + k)];
               b_step[i] = b_mem[AW'(k*N + i)];
            end
         end
      end
   end

   // sequencer: start edge loads step 0, FEED walks the steps, FLUSH waits
   // for the wavefront to drain, then a single-cycle done on return to IDLE
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         A_out <= '0;
         B_out <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= FEED;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  A_out <= a_step;
                  B_out <= b_step;
               end
            end
            default: begin
               cnt   <= cnt_inc;
               A_out <= a_step;
               B_out <= b_step;
               if (cnt_inc == LAST_CNT) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (cnt_inc <= LAST_STEP) begin
                  state <= FEED;
               end else begin
                  state <= FLUSH;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed + randomized sequences against a matrix
// level model; the recorded edge streams are also run through an ideal
// output-stationary array and compared with the plain matrix product.
module tb_systolic_skew_feeder;
   localparam int DW = 8;
   localparam int N  = 3;
   localparam int AW = $clog2(N*N);
   localparam int L  = 3*N - 2;

   logic             CLK = 1'b0;
   logic             RST;
   logic             wr_en;
   logic             wr_sel;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             start;
   logic             busy;
   logic             done;
   logic [N*DW-1:0]  A_out;
   logic [N*DW-1:0]  B_out;

   int checks = 0;
   int errors = 0;
   int am [N][N];
   int bm [N][N];
   int as [N][N];
   int bs [N][N];
   logic [N*DW-1:0] ra [L+1];
   logic [N*DW-1:0] rb [L+1];

   always #5 CLK = ~CLK;

   systolic_skew_feeder #(.DATAWIDTH(DW), .N(N)) dut (
      .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .busy(busy), .done(done),
      .A_out(A_out), .B_out(B_out)
   );

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // west-edge lanes at step s, straight from the matrix: lane i carries A[i][s-i]
   function automatic logic [N*DW-1:0] exp_a(input int s);
      logic [N*DW-1:0] v = '0;
      for (int i = 0; i < N; i++)
         if (s - i >= 0 && s - i < N) v[i*DW +: DW] = DW'(as[i][s-i]);
      return v;
   endfunction

   // north-edge lanes at step s: lane j carries B[s-j][j]
   function automatic logic [N*DW-1:0] exp_b(input int s);
      logic [N*DW-1:0] v = '0;
      for (int j = 0; j < N; j++)
         if (s - j >= 0 && s - j < N) v[j*DW +: DW] = DW'(bs[s-j][j]);
      return v;
   endfunction

   task automatic load(input bit sel, input int r, input int c, input int v);
      wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(r*N + c); wr_data = DW'(v);
      tick;
      wr_en = 1'b0;
      if (sel) bm[r][c] = v; else am[r][c] = v;
   endtask

   task automatic load_all;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            load(1'b0, r, c, am[r][c]);
            load(1'b1, r, c, bm[r][c]);
         end
   endtask

   // one full sequence; optional write / start injected while busy, optional
   // write on the start edge, optional fixed-value skew spot checks
   task automatic run_seq(input string name, input int wr_busy_t, input int st_busy_t,
                          input bit wr_with_start, input bit skew);
      longint obs, exp;
      as = am;
      bs = bm;
      start = 1'b1;
      if (wr_with_start) begin
         wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd77;
      end
      for (int t = 0; t <= L; t++) begin
         tick;
         if (t == 0 && wr_with_start) am[0][0] = 77;
         wr_en = 1'b0;
         start = 1'b0;
         ra[t] = A_out;
         rb[t] = B_out;
         chk($sformatf("%s busy t%0d", name, t), 64'(busy), 64'(t < L));
         chk($sformatf("%s done t%0d", name, t), 64'(done), 64'(t == L));
         chk($sformatf("%s A_out t%0d", name, t), 64'(A_out), 64'(exp_a(t)));
         chk($sformatf("%s B_out t%0d", name, t), 64'(B_out), 64'(exp_b(t)));
         if (skew && t == 2) chk({name, " skew A step2"}, 64'(A_out), 64'h14_0B_02);
         if (skew && t == 4) chk({name, " skew A step4"}, 64'(A_out), 64'h16_00_00);
         if (skew && t == 5) chk({name, " skew A|B step5"}, 64'(A_out | B_out), 64'h0);
         if (t == wr_busy_t) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd99;
         end
         if (t == st_busy_t) start = 1'b1;
      end
      tick;
      chk({name, " done after"}, 64'(done), 64'h0);
      chk({name, " busy after"}, 64'(busy), 64'h0);
      // ideal PE(i,j): A lane i delayed j cycles times B lane j delayed i cycles
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            obs = 0;
            exp = 0;
            for (int t = 0; t <= L + 2*N; t++)
               if (t - j >= 0 && t - j <= L && t - i >= 0 && t - i <= L)
                  obs += longint'(ra[t-j][i*DW +: DW]) * longint'(rb[t-i][j*DW +: DW]);
            for (int k = 0; k < N; k++) exp += longint'(as[i][k]) * longint'(bs[k][j]);
            chk($sformatf("%s PE(%0d,%0d)", name, i, j), 64'(obs), 64'(exp));
         end
   endtask

   initial begin
      RST = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin am[r][c] = 0; bm[r][c] = 0; end
      tick; tick;
      chk("reset busy", 64'(busy), 64'h0);
      chk("reset done", 64'(done), 64'h0);
      chk("reset A_out", 64'(A_out), 64'h0);
      chk("reset B_out", 64'(B_out), 64'h0);
      RST = 1'b0;
      tick;

      // identity times 1..9
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin am[r][c] = (r == c); bm[r][c] = r*N + c + 1; end
      load_all;
      run_seq("ident", -1, -1, 1'b0, 1'b0);

      // skew pattern, then write while busy, readback, start while busy
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin am[r][c] = 10*r + c; bm[r][c] = 10*r + c; end
      load_all;
      run_seq("skew", -1, -1, 1'b0, 1'b1);
      run_seq("wrbusy", 1, -1, 1'b0, 1'b0);
      run_seq("rdback", -1, -1, 1'b0, 1'b0);
      run_seq("stbusy", -1, 3, 1'b0, 1'b0);

      // out-of-range address must not land anywhere
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = AW'(N*N); wr_data = 8'd5;
      tick;
      wr_sel = 1'b1;
      tick;
      wr_en = 1'b0;
      run_seq("oob", -1, -1, 1'b0, 1'b0);

      // write on the start edge: step 0 uses the old word, next run the new one
      run_seq("wrstart", -1, -1, 1'b1, 1'b0);
      run_seq("wrstart2", -1, -1, 1'b0, 1'b0);

      // saturating operands
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin am[r][c] = 255; bm[r][c] = 255; end
      load_all;
      run_seq("sat", -1, -1, 1'b0, 1'b0);

      // random matrices
      for (int n = 0; n < 3; n++) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               am[r][c] = int'($urandom_range(0, 255));
               bm[r][c] = int'($urandom_range(0, 255));
            end
         load_all;
         run_seq($sformatf("rand%0d", n), -1, -1, 1'b0, 1'b0);
      end

      // asynchronous reset in the middle of FEED
      as = am;
      bs = bm;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      chk("prerst A_out", 64'(A_out), 64'(exp_a(2)));
      #2 RST = 1'b1;
      #1;
      chk("rst A_out", 64'(A_out), 64'h0);
      chk("rst B_out", 64'(B_out), 64'h0);
      chk("rst busy", 64'(busy), 64'h0);
      chk("rst done", 64'(done), 64'h0);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin am[r][c] = 0; bm[r][c] = 0; end
      tick; tick;
      RST = 1'b0;
      for (int t = 0; t < L; t++) begin
         tick;
         chk($sformatf("postrst done t%0d", t), 64'(done), 64'h0);
      end
      run_seq("cleared", -1, -1, 1'b0, 1'b0);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            am[r][c] = int'($urandom_range(0, 255));
            bm[r][c] = int'($urandom_range(0, 255));
         end
      load_all;
      run_seq("fresh", -1, -1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
